// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM state encoding for the fetch unit and its line storage.
package fetch_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DRAIN  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_icache_array.sv
// Direct-mapped line storage: valid bits (reset), tag and data arrays (no reset),
// one write port and one combinational read port.
module icache_array
    import fetch_unit_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4,
    parameter int TAG_BITS   = 24,
    parameter int OFFSET_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inval,
    input  logic                  write,
    input  logic                  fill,
    input  logic [INDEX_BITS-1:0] write_index,
    input  logic [OFFSET_W-1:0]   write_word,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [INDEX_BITS-1:0] read_index,
    input  logic [OFFSET_W-1:0]   read_word,
    output logic                  read_valid,
    output logic [TAG_BITS-1:0]   read_tag,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags  [LINES];
    logic [DATA_WIDTH-1:0] words [LINES][LINE_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (inval) begin
            valid[write_index] <= FALSE;
        end else if (fill) begin
            valid[write_index] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            words[write_index][write_word] <= write_data;
        end
        if (fill) begin
            tags[write_index] <= fill_tag;
        end
    end

    assign read_valid = valid[read_index];
    assign read_tag   = tags[read_index];
    assign read_data  = words[read_index][read_word];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a direct-mapped, hit-under-miss instruction cache.
// Define ICACHE_STATS_EN to add the hit/miss statistics counters and their ports.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  in_result_taken,
    output logic                  out_decoder_ena,
    output logic                  out_pc_reg_ena,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0] out_decoder_pc,
    output logic                  out_branch_taken,
    output logic                  out_mem_ena,
    output logic [DATA_WIDTH-1:0] out_address,
    input  logic                  in_mem_ready,
    input  logic [DATA_WIDTH-1:0] in_mem_inst
`ifdef ICACHE_STATS_EN
    ,
    output logic [DATA_WIDTH-1:0] out_hit_cnt,
    output logic [DATA_WIDTH-1:0] out_miss_cnt
`endif
);

    localparam int OFFSET_BITS = $clog2(LINE_WORDS);
    localparam int OFFSET_W    = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int TAG_BITS    = DATA_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;
    localparam int LINE_BYTES  = LINE_WORDS * 4;

    fetch_state_t state, state_next;

    logic [OFFSET_W-1:0]   pc_offset;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [DATA_WIDTH-1:0] miss_base;

    logic [TAG_BITS-1:0]   fill_tag, fill_tag_next;
    logic [INDEX_BITS-1:0] fill_index, fill_index_next;
    logic [OFFSET_W-1:0]   word_cnt, word_next, word_inc;
    logic                  outstanding, outstanding_next;
    logic                  mem_ena_next;
    logic [DATA_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] req_base;
    logic                  last_word;

    logic                  start_miss, arr_write, arr_fill;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  hit;

    assign pc_index  = in_pc[2 + OFFSET_BITS +: INDEX_BITS];
    assign pc_tag    = in_pc[DATA_WIDTH-1 -: TAG_BITS];
    assign miss_base = in_pc & ~DATA_WIDTH'(LINE_BYTES - 1);

    // A one-word line has no offset field; word select is then constant zero.
    generate
        if (OFFSET_BITS > 0) begin : g_offset
            assign pc_offset = in_pc[2 +: OFFSET_W];
        end else begin : g_no_offset
            assign pc_offset = '0;
        end
    endgenerate

    assign req_base  = (DATA_WIDTH'(fill_tag) << (DATA_WIDTH - TAG_BITS))
                     | (DATA_WIDTH'(fill_index) << (2 + OFFSET_BITS));
    assign word_inc  = word_cnt + OFFSET_W'(1);
    assign last_word = (word_cnt == OFFSET_W'(LINE_WORDS - 1));

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS),
        .OFFSET_W   (OFFSET_W)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .inval       (start_miss),
        .write       (arr_write),
        .fill        (arr_fill),
        .write_index (start_miss ? pc_index : fill_index),
        .write_word  (word_cnt),
        .write_data  (in_mem_inst),
        .fill_tag    (fill_tag),
        .read_index  (pc_index),
        .read_word   (pc_offset),
        .read_valid  (rd_valid),
        .read_tag    (rd_tag),
        .read_data   (out_inst)
    );

    assign hit              = rd_valid && (rd_tag == pc_tag);
    assign out_decoder_ena  = hit && ena;
    assign out_pc_reg_ena   = out_decoder_ena;
    assign out_decoder_pc   = in_pc;
    assign out_branch_taken = in_result_taken;

    // The first request issues on the miss edge; each later one on the edge that accepts the previous ready.
    always_comb begin
        state_next       = state;
        fill_tag_next    = fill_tag;
        fill_index_next  = fill_index;
        word_next        = word_cnt;
        outstanding_next = outstanding;
        mem_ena_next     = FALSE;
        address_next     = out_address;
        start_miss       = FALSE;
        arr_write        = FALSE;
        arr_fill         = FALSE;
        case (state)
            IDLE: begin
                if (ena && !hit && !in_rollback) begin
                    start_miss       = TRUE;
                    state_next       = REFILL;
                    fill_tag_next    = pc_tag;
                    fill_index_next  = pc_index;
                    word_next        = '0;
                    outstanding_next = TRUE;
                    mem_ena_next     = TRUE;
                    address_next     = miss_base;
                end
            end
            REFILL: begin
                if (in_rollback) begin
                    word_next = '0;
                    if (outstanding && !in_mem_ready) begin
                        state_next = DRAIN;
                    end else begin
                        state_next       = IDLE;
                        outstanding_next = FALSE;
                    end
                end else if (in_mem_ready && outstanding) begin
                    arr_write = TRUE;
                    if (last_word) begin
                        arr_fill         = TRUE;
                        state_next       = IDLE;
                        word_next        = '0;
                        outstanding_next = FALSE;
                    end else begin
                        word_next    = word_inc;
                        mem_ena_next = TRUE;
                        address_next = req_base | (DATA_WIDTH'(word_inc) << 2);
                    end
                end
            end
            DRAIN: begin
                if (in_mem_ready) begin
                    state_next       = IDLE;
                    outstanding_next = FALSE;
                end
            end
            default: begin
                state_next       = IDLE;
                outstanding_next = FALSE;
                word_next        = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fill_tag    <= '0;
            fill_index  <= '0;
            word_cnt    <= '0;
            outstanding <= FALSE;
            out_mem_ena <= FALSE;
            out_address <= ZERO_DATA;
        end else begin
            state       <= state_next;
            fill_tag    <= fill_tag_next;
            fill_index  <= fill_index_next;
            word_cnt    <= word_next;
            outstanding <= outstanding_next;
            out_mem_ena <= mem_ena_next;
            out_address <= address_next;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hit_cnt  <= ZERO_DATA;
            out_miss_cnt <= ZERO_DATA;
        end else begin
            if (out_decoder_ena) begin
                out_hit_cnt <= out_hit_cnt + DATA_WIDTH'(1);
            end
            if (start_miss) begin
                out_miss_cnt <= out_miss_cnt + DATA_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning log2 of the number of cache lines.
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line; must be a power of two, at least 1.
REQ-003 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-004 SHALL have ena (in, 1, fetch enable) and in_rollback (in, 1, flush the in-flight miss).
REQ-005 SHALL have in_pc (in, 32, fetch PC) and in_result_taken (in, 1, predictor taken bit for in_pc).
REQ-006 SHALL have out_decoder_ena (out, 1, instruction valid this cycle) and out_pc_reg_ena (out, 1, PC advance; equals out_decoder_ena).
REQ-007 SHALL have out_inst (out, 32), out_decoder_pc (out, 32) and out_branch_taken (out, 1), all to the decoder.
REQ-008 SHALL have out_mem_ena (out, 1, single-cycle read request) and out_address (out, 32, word address).
REQ-009 SHALL have in_mem_ready (in, 1, one-cycle read-data strobe) and in_mem_inst (in, 32, read data).
REQ-010 SHALL have, only with ICACHE_STATS_EN defined, out_hit_cnt and out_miss_cnt (out, 32 each).

Function
REQ-011 SHALL split in_pc as: bits [1:0] ignored; offset = next log2(LINE_WORDS) bits; index = next INDEX_BITS bits; tag = remaining upper bits.
REQ-012 SHALL form hit combinationally as valid[index] && tag match; out_decoder_ena = hit && ena; out_inst = word[index][offset]; out_decoder_pc = in_pc; out_branch_taken = in_result_taken.
REQ-013 SHALL serve hits in every FSM state (hit-under-miss), with zero-cycle latency.
REQ-014 SHALL implement FSM states IDLE, REFILL and DRAIN.
REQ-015 IDLE -> REFILL: on ena && !hit && !in_rollback; latch line base (in_pc with offset and low bits zeroed), tag and index; clear valid[index] on the same edge.
REQ-016 In REFILL, SHALL issue word requests k = 0..LINE_WORDS-1 at address base + 4k, at most one outstanding; each request is a one-cycle out_mem_ena pulse.
REQ-017 SHALL issue the next request on the cycle after the previous in_mem_ready, so the minimum per-word spacing is 2 cycles.
REQ-018 On each in_mem_ready, SHALL write in_mem_inst to word k of the latched index.
REQ-019 On the last word, SHALL set valid and tag and return to IDLE; the line hits on the following cycle.
REQ-020 in_rollback in REFILL with a request outstanding and no in_mem_ready: SHALL go to DRAIN; in_mem_ready in DRAIN is discarded -> IDLE.
REQ-021 in_rollback in REFILL with nothing outstanding, or coinciding with in_mem_ready: SHALL discard that data and go to IDLE.
REQ-022 An aborted line SHALL stay invalid; no new miss SHALL start in the rollback cycle.
REQ-023 SHALL keep out_address holding its last value while out_mem_ena is low.
REQ-024 SHALL ignore in_mem_ready in IDLE.
REQ-025 SHALL wrap the word counter modulo LINE_WORDS; it never exceeds LINE_WORDS-1.

Reset
REQ-026 While rst_n is low, SHALL force all valid bits to 0, FSM to IDLE, out_mem_ena to 0, out_address to 0, outstanding flag and word counter to 0, and statistics counters to 0.
REQ-027 Reset mid-refill SHALL abandon the refill; a late in_mem_ready after reset SHALL be ignored (IDLE rule).
REQ-028 Data and tag arrays SHALL need no reset.

Configuration
REQ-029 With ICACHE_STATS_EN defined, out_hit_cnt SHALL increment on each cycle with out_decoder_ena = 1.
REQ-030 With ICACHE_STATS_EN defined, out_miss_cnt SHALL increment on each IDLE -> REFILL transition; both counters wrap at 2^32.
REQ-031 Without ICACHE_STATS_EN, the counters and their ports SHALL be absent.

Structure
REQ-032 The shared constants package SHALL hold DATA_WIDTH, TRUE/FALSE, ZERO_DATA and the FSM state encoding.
REQ-033 The line storage (valid/tag/data arrays, one write port, one combinational read port) SHALL be a sub-module named icache_array.

Verification
REQ-034 Cold miss, defaults: in_pc = 0x100, memory latency 3 -> requests 0x100, 0x104, 0x108, 0x10C; hit on 0x100 the cycle after the fourth ready; then 0x104..0x10C hit with no request.
REQ-035 Hit-under-miss: 0x100 line resident, miss on 0x2000 in progress, in_pc switched to 0x108 -> out_decoder_ena = 1 with the correct word.
REQ-036 Rollback with a request outstanding -> DRAIN; the ready is discarded; the line reads invalid; a new miss to 0x400 refills it correctly.
REQ-037 Rollback in the same cycle as the last ready -> IDLE, line invalid, no write of that data.
REQ-038 Conflict miss: 0x0 then 0x1000 (same index, INDEX_BITS = 6, LINE_WORDS = 4) -> second line evicts the first; 0x0 misses again.
REQ-039 rst_n low mid-refill with ready one cycle later -> no array write; with ICACHE_STATS_EN, counters read 0; the LINE_WORDS = 1, INDEX_BITS = 2 build passes the same tests.
